// File: rtl/blit_bus_responder.sv
// ---------------------------------------------------------------------------
// blit_bus_responder
//
// Memory-side target for the blitter bus master. Arbitrates the blitter bus
// request into a registered grant, accepts one read/write cycle at a time,
// and turns it into a single phrase-wide memory request with byte enables.
// It completes each cycle with a one-cycle ack. Read data is returned
// lane-aligned according to justify.
//
// Ports
//   clk, reset_n         clock, asynchronous active-low reset
//   blit_breq[1:0]       bus request ([1] high priority, [0] normal)
//   ext_busy             another master owns memory; blocks new grants only
//   blit_back            bus grant to the blitter
//   mreq, read, width,   transaction strobe and fields, sampled while
//   address, justify,    granted and idle
//   wdata
//   ack, rdata           one-cycle completion pulse, read data (held)
//   mem_req, mem_we,     generic memory port; request held until mem_ready
//   mem_addr, mem_be,
//   mem_wdata
//   mem_rdata, mem_ready memory read data / one-cycle completion
// ---------------------------------------------------------------------------
module blit_bus_responder #(
  parameter int unsigned GRANT_DLY   = 2,  // 0..15
  parameter int unsigned WAIT_STATES = 1   // 0..7
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [1:0]  blit_breq,
  input  logic        ext_busy,
  output logic        blit_back,
  input  logic        mreq,
  input  logic        read,
  input  logic [3:0]  width,
  input  logic [23:0] address,
  input  logic        justify,
  input  logic [63:0] wdata,
  output logic        ack,
  output logic [63:0] rdata,
  output logic        mem_req,
  output logic        mem_we,
  output logic [20:0] mem_addr,
  output logic [7:0]  mem_be,
  output logic [63:0] mem_wdata,
  input  logic [63:0] mem_rdata,
  input  logic        mem_ready
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_GWAIT,
    S_OWNED,
    S_MEM,
    S_WAIT,
    S_ACKS
  } state_t;

  state_t      r_state;
  logic [3:0]  r_cnt;        // shared grant-delay / wait-state counter
  logic        r_read;
  logic        r_justify;
  logic [3:0]  r_n;          // effective byte count 1..8
  logic [2:0]  r_off;        // byte offset inside the phrase
  logic [63:0] r_rdata_hold; // formatted read data waiting out the wait states

  // -------------------------------------------------------------------------
  // Request-side byte arithmetic, evaluated from the live inputs so the
  // memory port fields can be registered on the accepting edge.
  // -------------------------------------------------------------------------
  logic [3:0]  w_n;
  logic [15:0] w_run;
  logic [7:0]  w_mask;
  logic [63:0] w_wdata_mem;

  // NOTE: every combinational output is assigned on every path through the
  // block; a path that skips an assignment would infer a latch.
  always_comb begin
    w_n         = (width == 4'd0 || width > 4'd8) ? 4'd8 : width;
    w_run       = (16'd1 << w_n) - 16'd1;
    // Bits shifted past lane 7 are dropped: a phrase-crossing transfer is
    // clipped rather than split.
    w_mask      = 8'(w_run << address[2:0]);
    w_wdata_mem = justify ? (wdata << {address[2:0], 3'b000}) : wdata;
  end

  // -------------------------------------------------------------------------
  // Read-side formatting from the latched cycle fields.
  // Right-justified reads keep the low n bytes of the shifted phrase; the
  // shift itself already zeroes lanes beyond the phrase end. Unjustified
  // reads keep only the enabled lanes.
  // -------------------------------------------------------------------------
  logic [15:0] w_keep_run;
  logic [7:0]  w_keep;
  logic [63:0] w_keep_bits;
  logic [63:0] w_rd_src;
  logic [63:0] w_rdata_fmt;

  always_comb begin
    w_keep_run = (16'd1 << r_n) - 16'd1;
    w_keep     = r_justify ? w_keep_run[7:0] : mem_be;
    w_rd_src   = r_justify ? (mem_rdata >> {r_off, 3'b000}) : mem_rdata;
    for (int i = 0; i < 8; i++) begin
      w_keep_bits[8*i +: 8] = {8{w_keep[i]}};
    end
    w_rdata_fmt = w_rd_src & w_keep_bits;
  end

  // -------------------------------------------------------------------------
  // Arbitration and transaction FSM; all outputs are registered here.
  // -------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state      <= S_IDLE;
      r_cnt        <= '0;
      r_read       <= 1'b0;
      r_justify    <= 1'b0;
      r_n          <= '0;
      r_off        <= '0;
      r_rdata_hold <= '0;
      blit_back    <= 1'b0;
      ack          <= 1'b0;
      rdata        <= '0;
      mem_req      <= 1'b0;
      mem_we       <= 1'b0;
      mem_addr     <= '0;
      mem_be       <= '0;
      mem_wdata    <= '0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments only; this
      // default makes ack a single-cycle pulse unless ACKS entry re-sets it.
      ack <= 1'b0;

      case (r_state)
        S_IDLE: begin
          if (!ext_busy) begin
            if (blit_breq[1] || (blit_breq[0] && GRANT_DLY == 0)) begin
              r_state   <= S_OWNED;
              blit_back <= 1'b1;
            end else if (blit_breq[0]) begin
              r_state <= S_GWAIT;
              r_cnt   <= 4'(GRANT_DLY);
            end
          end
        end

        S_GWAIT: begin
          // Entry required ext_busy low and breq[1] low, so a high level
          // here is a rising edge.
          if (blit_breq == 2'b00 || ext_busy) begin
            r_state <= S_IDLE;
          end else if (blit_breq[1] || r_cnt <= 4'd1) begin
            r_state   <= S_OWNED;
            blit_back <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_OWNED: begin
          // A strobe wins over a dropped request: the cycle is accepted and
          // the grant is released after its ack.
          if (mreq) begin
            r_state   <= S_MEM;
            r_read    <= read;
            r_justify <= justify;
            r_n       <= w_n;
            r_off     <= address[2:0];
            mem_req   <= 1'b1;
            mem_we    <= ~read;
            mem_addr  <= address[23:3];
            mem_be    <= w_mask;
            mem_wdata <= w_wdata_mem;
          end else if (blit_breq == 2'b00) begin
            r_state   <= S_IDLE;
            blit_back <= 1'b0;
          end
        end

        S_MEM: begin
          if (mem_ready) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (WAIT_STATES == 0) begin
              r_state <= S_ACKS;
              ack     <= 1'b1;
              if (r_read) rdata <= w_rdata_fmt;
            end else begin
              r_state      <= S_WAIT;
              r_cnt        <= 4'(WAIT_STATES);
              r_rdata_hold <= w_rdata_fmt;
            end
          end
        end

        S_WAIT: begin
          if (r_cnt <= 4'd1) begin
            r_state <= S_ACKS;
            ack     <= 1'b1;
            if (r_read) rdata <= r_rdata_hold;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end

        S_ACKS: begin
          if (blit_breq != 2'b00) begin
            r_state <= S_OWNED;
          end else begin
            r_state   <= S_IDLE;
            blit_back <= 1'b0;
          end
        end

        default: begin
          r_state   <= S_IDLE;
          blit_back <= 1'b0;
          mem_req   <= 1'b0;
          mem_we    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_blit_bus_responder.sv
// ---------------------------------------------------------------------------
// tb_blit_bus_responder
//
// Self-checking bench: grant latency and release sequences, a table of
// directed read/write vectors, randomized transactions against a byte-level
// reference model, ext_busy blocking and asynchronous reset mid-transaction.
// ---------------------------------------------------------------------------
module tb_blit_bus_responder;

  localparam int GRANT_DLY   = 2;
  localparam int WAIT_STATES = 1;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [1:0]  blit_breq;
  logic        ext_busy;
  logic        blit_back;
  logic        mreq;
  logic        read;
  logic [3:0]  width;
  logic [23:0] address;
  logic        justify;
  logic [63:0] wdata;
  logic        ack;
  logic [63:0] rdata;
  logic        mem_req;
  logic        mem_we;
  logic [20:0] mem_addr;
  logic [7:0]  mem_be;
  logic [63:0] mem_wdata;
  logic [63:0] mem_rdata;
  logic        mem_ready;

  always #5 clk = ~clk;

  blit_bus_responder #(
    .GRANT_DLY  (GRANT_DLY),
    .WAIT_STATES(WAIT_STATES)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .blit_breq(blit_breq),
    .ext_busy (ext_busy),
    .blit_back(blit_back),
    .mreq     (mreq),
    .read     (read),
    .width    (width),
    .address  (address),
    .justify  (justify),
    .wdata    (wdata),
    .ack      (ack),
    .rdata    (rdata),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_be   (mem_be),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    logic        rd;
    logic [23:0] addr;
    logic [3:0]  width;
    logic        just;
    logic [63:0] wd;
    logic [63:0] mrd;
    logic [20:0] exp_addr;
    logic [7:0]  exp_be;
    logic [63:0] exp_wd;
    logic [63:0] exp_rd;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled and inputs driven 1 ns later.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_all_zero(input string name);
    check({name, " blit_back"}, blit_back, 0);
    check({name, " ack"},       ack,       0);
    check({name, " mem_req"},   mem_req,   0);
    check({name, " mem_we"},    mem_we,    0);
    check({name, " mem_addr"},  mem_addr,  0);
    check({name, " mem_be"},    mem_be,    0);
    check({name, " mem_wdata"}, mem_wdata, 0);
    check({name, " rdata"},     rdata,     0);
  endtask

  // Reference model: per-lane rules straight from the byte arithmetic.
  function automatic void model(input logic [23:0] a, input logic [3:0] w,
                                input logic j, input logic [63:0] wd,
                                input logic [63:0] mrd,
                                output logic [7:0] be, output logic [63:0] mwd,
                                output logic [63:0] rd);
    int n;
    int o;
    n   = (w == 4'd0 || w > 4'd8) ? 8 : int'(w);
    o   = int'(a[2:0]);
    be  = '0;
    mwd = '0;
    rd  = '0;
    for (int i = 0; i < 8; i++) begin
      if (i >= o && i < o + n) be[i] = 1'b1;
      if (j) begin
        if (i >= o) mwd[8*i +: 8] = wd[8*(i-o) +: 8];
        if (i < n && i + o < 8) rd[8*i +: 8] = mrd[8*(i+o) +: 8];
      end else begin
        mwd[8*i +: 8] = wd[8*i +: 8];
        if (be[i]) rd[8*i +: 8] = mrd[8*i +: 8];
      end
    end
  endfunction

  // One complete transaction starting from the granted idle state.
  // lat = cycles mem_ready is withheld after the request appears.
  task automatic run_txn(input string name, input logic rd_i,
                         input logic [23:0] a, input logic [3:0] w,
                         input logic j, input logic [63:0] wd,
                         input logic [63:0] mrd, input int lat,
                         input logic [20:0] exp_addr, input logic [7:0] exp_be,
                         input logic [63:0] exp_wd, input logic [63:0] exp_rd);
    read    = rd_i;
    address = a;
    width   = w;
    justify = j;
    wdata   = wd;
    mreq    = 1'b1;
    tick();
    // Fields are latched; scramble them and keep mreq up while busy to show
    // the responder ignores both.
    address = 24'($urandom);
    wdata   = {$urandom, $urandom};
    mreq    = (lat > 0);
    check({name, " mem_req"},  mem_req,  1);
    check({name, " mem_we"},   mem_we,   !rd_i);
    check({name, " mem_addr"}, mem_addr, exp_addr);
    check({name, " mem_be"},   mem_be,   exp_be);
    if (!rd_i) check({name, " mem_wdata"}, mem_wdata, exp_wd);
    for (int k = 0; k < lat; k++) begin
      tick();
      check({name, " mem_req held"}, mem_req, 1);
      check({name, " no early ack"}, ack, 0);
    end
    mreq      = 1'b0;
    mem_ready = 1'b1;
    mem_rdata = mrd;
    tick();
    mem_ready = 1'b0;
    mem_rdata = {$urandom, $urandom};
    check({name, " mem_req drop"}, mem_req, 0);
    for (int k = 0; k < WAIT_STATES; k++) begin
      check({name, " ack in wait"}, ack, 0);
      tick();
    end
    check({name, " ack"}, ack, 1);
    if (rd_i) check({name, " rdata"}, rdata, exp_rd);
    tick();
    check({name, " ack pulse end"}, ack, 0);
    if (rd_i) check({name, " rdata held"}, rdata, exp_rd);
  endtask

  initial begin
    #200_000;
    $display("FAIL watchdog: time limit reached, got no end, expected end of test");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n   = 1'b0;
    blit_breq = 2'b00;
    ext_busy  = 1'b0;
    mreq      = 1'b0;
    read      = 1'b0;
    width     = '0;
    address   = '0;
    justify   = 1'b0;
    wdata     = '0;
    mem_rdata = '0;
    mem_ready = 1'b0;

    //                rd   addr        w     j     wdata                  mem_rdata              addr      be     mem_wdata              rdata
    vecs[0] = '{1'b0, 24'h000105, 4'd2, 1'b1, 64'h000000000000BEEF, 64'h0,                 21'h000020, 8'h60, 64'h00BEEF0000000000, 64'h0};
    vecs[1] = '{1'b1, 24'h000102, 4'd4, 1'b1, 64'h0,                64'h1122334455667788, 21'h000020, 8'h3C, 64'h0,                64'h0000000033445566};
    vecs[2] = '{1'b1, 24'h00000E, 4'd8, 1'b1, 64'h0,                64'h1122334455667788, 21'h000001, 8'hC0, 64'h0,                64'h0000000000001122};
    vecs[3] = '{1'b1, 24'h000200, 4'd0, 1'b0, 64'h0,                64'hCAFEBABEDEADBEEF, 21'h000040, 8'hFF, 64'h0,                64'hCAFEBABEDEADBEEF};
    vecs[4] = '{1'b1, 24'h000013, 4'd3, 1'b0, 64'h0,                64'h1122334455667788, 21'h000002, 8'h38, 64'h0,                64'h0000334455000000};
    vecs[5] = '{1'b0, 24'hFFFFFC, 4'd9, 1'b0, 64'h0102030405060708, 64'h0,                21'h1FFFFF, 8'hF0, 64'h0102030405060708, 64'h0};
    vecs[6] = '{1'b0, 24'h000007, 4'd1, 1'b1, 64'h00000000000000AB, 64'h0,                21'h000000, 8'h80, 64'hAB00000000000000, 64'h0};
    vecs[7] = '{1'b1, 24'h000031, 4'd1, 1'b1, 64'h0,                64'h1122334455667788, 21'h000006, 8'h02, 64'h0,                64'h0000000000000077};

    // ---- reset state ----
    #12;
    check_all_zero("reset");
    tick();
    reset_n = 1'b1;

    // ---- normal request: grant after 1 + GRANT_DLY cycles ----
    blit_breq = 2'b01;
    tick();
    check("lowpri cycle1 blit_back", blit_back, 0);
    tick();
    check("lowpri cycle2 blit_back", blit_back, 0);
    tick();
    check("lowpri cycle3 blit_back", blit_back, 1);

    // ---- request dropped while owned: grant falls next cycle ----
    blit_breq = 2'b00;
    tick();
    check("owned release blit_back", blit_back, 0);

    // ---- high-priority request: grant after 1 cycle ----
    blit_breq = 2'b10;
    tick();
    check("hipri blit_back", blit_back, 1);

    // ---- directed vector table ----
    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vecs[i].rd, vecs[i].addr, vecs[i].width,
              vecs[i].just, vecs[i].wd, vecs[i].mrd, i % 3, vecs[i].exp_addr,
              vecs[i].exp_be, vecs[i].exp_wd, vecs[i].exp_rd);
    end

    // ---- randomized transactions against the model ----
    for (int t = 0; t < 40; t++) begin
      logic        r_rd;
      logic [23:0] r_a;
      logic [3:0]  r_w;
      logic        r_j;
      logic [63:0] r_wd;
      logic [63:0] r_mrd;
      logic [7:0]  e_be;
      logic [63:0] e_wd;
      logic [63:0] e_rd;
      r_rd  = 1'($urandom_range(0, 1));
      r_a   = 24'($urandom);
      r_w   = 4'($urandom_range(0, 15));
      r_j   = 1'($urandom_range(0, 1));
      r_wd  = {$urandom, $urandom};
      r_mrd = {$urandom, $urandom};
      blit_breq = 2'($urandom_range(1, 3));
      ext_busy  = 1'($urandom_range(0, 1));
      model(r_a, r_w, r_j, r_wd, r_mrd, e_be, e_wd, e_rd);
      run_txn($sformatf("rnd%0d", t), r_rd, r_a, r_w, r_j, r_wd, r_mrd,
              int'($urandom_range(0, 3)), r_a[23:3], e_be, e_wd, e_rd);
      check($sformatf("rnd%0d grant kept", t), blit_back, 1);
    end
    ext_busy  = 1'b0;
    blit_breq = 2'b10;

    // ---- request dropped during MEM: ack still issued, then release ----
    read    = 1'b0;
    address = 24'h000040;
    width   = 4'd8;
    justify = 1'b0;
    wdata   = 64'h5555AAAA5555AAAA;
    mreq    = 1'b1;
    tick();
    mreq      = 1'b0;
    blit_breq = 2'b00;
    check("drop in MEM mem_req", mem_req, 1);
    tick();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    check("drop in MEM ack", ack, 1);
    check("drop in MEM grant during ack", blit_back, 1);
    tick();
    check("drop in MEM grant after ack", blit_back, 0);

    // ---- mreq and request drop together: accepted, released after ack ----
    blit_breq = 2'b10;
    tick();
    check("regrant blit_back", blit_back, 1);
    mreq      = 1'b1;
    blit_breq = 2'b00;
    tick();
    mreq = 1'b0;
    check("same-cycle drop mem_req", mem_req, 1);
    check("same-cycle drop blit_back", blit_back, 1);
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    tick();
    check("same-cycle drop ack", ack, 1);
    tick();
    check("same-cycle drop release", blit_back, 0);

    // ---- ext_busy during GWAIT: no grant, and none while it stays high ----
    begin
      int backs;
      backs     = 0;
      blit_breq = 2'b01;
      tick();
      ext_busy = 1'b1;
      for (int k = 0; k < 5; k++) begin
        tick();
        if (blit_back) backs++;
      end
      blit_breq = 2'b10;
      for (int k = 0; k < 2; k++) begin
        tick();
        if (blit_back) backs++;
      end
      check("ext_busy grant cycles", backs, 0);
      ext_busy = 1'b0;
      tick();
      check("grant after ext_busy clears", blit_back, 1);
    end

    // ---- asynchronous reset mid-transaction ----
    read    = 1'b1;
    address = 24'h000080;
    width   = 4'd8;
    mreq    = 1'b1;
    tick();
    mreq = 1'b0;
    check("pre-reset mem_req", mem_req, 1);
    #2;
    reset_n = 1'b0;
    #1;
    check_all_zero("async reset");
    blit_breq = 2'b00;
    @(posedge clk);
    #1;
    reset_n   = 1'b1;
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    begin
      int acks;
      int backs;
      acks  = 0;
      backs = 0;
      for (int k = 0; k < 5; k++) begin
        if (ack) acks++;
        if (blit_back) backs++;
        tick();
      end
      check("post-reset ack count", acks, 0);
      check("post-reset grant cycles", backs, 0);
      check("post-reset mem_req", mem_req, 0);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
